// File: rtl/jc_pkg.sv
// Shared Johnson-code definitions: FSM states, index width, legality and decode.
// Pure declarations and functions; no timing of its own.
// No flow control; reused by the decoder and by generator-side assertions.
package jc_pkg;

  // Widest code the helper functions accept; callers zero-extend into this.
  localparam int JC_MAX_W = 32;

  // One-hot receive states.
  typedef enum logic [2:0] {
    HUNT   = 3'b001,
    CHECK  = 3'b010,
    LOCKED = 3'b100
  } jc_state_e;

  // Bits needed to hold an index 0..2*width-1.
  function automatic int jc_idx_w(input int width);
    return $clog2(2 * width);
  endfunction

  // A Johnson code has at most one boundary between its run of ones and zeros.
  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code, input int width);
    int trans;
    trans = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < width - 1) && (code[i] ^ code[i+1])) trans++;
    end
    return (trans <= 1);
  endfunction

  // Ones filling from the MSB count up; ones draining from the MSB count on past width.
  function automatic int jc_decode(input logic [JC_MAX_W-1:0] code, input int width);
    int p;
    p = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if ((i < width) && code[i]) p++;
    end
    if (code[width-1]) return p;
    return (2 * width - p) % (2 * width);
  endfunction

endpackage

// File: rtl/jc_decoder_if.sv
// Bundle between a Johnson-code source and the decoder; dir exists only with JC_DEC_BIDIR_EN.
// No logic; decoder outputs are registered one cycle after the jc_valid sample.
// No backpressure: jc_valid is a strobe and the decoder accepts every sample.
interface jc_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IW = jc_pkg::jc_idx_w(WIDTH);

  logic [WIDTH-1:0]     jc_in;
  logic                 jc_valid;
  logic [IW-1:0]        cnt;
  logic                 cnt_valid;
  logic                 code_err;
  logic                 seq_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;
`ifdef JC_DEC_BIDIR_EN
  logic                 dir;
`endif

  modport master (
    output jc_in, jc_valid,
    input  cnt, cnt_valid, code_err, seq_err, locked, err_cnt
`ifdef JC_DEC_BIDIR_EN
    , input dir
`endif
  );

  modport slave (
    input  jc_in, jc_valid,
    output cnt, cnt_valid, code_err, seq_err, locked, err_cnt
`ifdef JC_DEC_BIDIR_EN
    , output dir
`endif
  );

endinterface

// File: rtl/jc_code_classify.sv
// Classifies one Johnson code sample as legal/illegal and decodes its index.
// Purely combinational, zero cycles.
// No flow control; evaluated every cycle regardless of jc_valid.
module jc_code_classify
  import jc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = jc_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IW-1:0]    idx_o
);

  logic [JC_MAX_W-1:0] code_ext;

  assign code_ext = JC_MAX_W'(code_i);
  assign legal_o  = jc_legal(code_ext, WIDTH);
  assign idx_o    = IW'(jc_decode(code_ext, WIDTH));

endmodule

// File: rtl/jc_decoder.sv
// Johnson-code receive checker: decode, error flags, hunt/lock FSM (JC_DEC_BIDIR_EN adds dir).
// All outputs registered, one cycle after the jc_valid sample.
// No backpressure: every strobed sample is consumed; idle cycles freeze all state.
module jc_decoder
  import jc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  jc_decoder_if.slave bus
);

  localparam int N  = 2 * WIDTH;
  localparam int IW = jc_idx_w(WIDTH);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_ERRS + 1);

  jc_state_e            state_q, state_d;
  logic [IW-1:0]        prev_q, prev_d;
  logic [RW-1:0]        run_q, run_d;
  logic [MW-1:0]        miss_q, miss_d;
  logic [IW-1:0]        cnt_q;
  logic                 cnt_valid_q, code_err_q, seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 legal;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        exp_up;
  logic                 is_up, in_seq, take_err;

  jc_code_classify #(.WIDTH(WIDTH), .IW(IW)) u_classify (
    .code_i  (bus.jc_in),
    .legal_o (legal),
    .idx_o   (idx)
  );

  assign exp_up = (prev_q == IW'(N - 1)) ? '0 : prev_q + 1'b1;
  assign is_up  = (idx == exp_up);

`ifdef JC_DEC_BIDIR_EN
  logic [IW-1:0] exp_dn;
  logic          is_dn;
  logic          dir_q, dir_d;

  assign exp_dn = (prev_q == '0) ? IW'(N - 1) : prev_q - 1'b1;
  assign is_dn  = (idx == exp_dn);
  assign in_seq = legal && (is_up || is_dn);

  // Direction follows the last in-sequence step once a seed exists.
  always_comb begin
    dir_d = dir_q;
    if (bus.jc_valid && legal && (state_q != HUNT)) begin
      if (is_dn)      dir_d = 1'b1;
      else if (is_up) dir_d = 1'b0;
    end
  end

  // Direction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end

  assign bus.dir = dir_q;
`else
  assign in_seq = legal && is_up;
`endif

  // Hunt/lock next state; LOCKED flywheels over illegal codes using the expected index.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    miss_d    = miss_q;
    seq_err_d = 1'b0;
    if (bus.jc_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            prev_d  = idx;
            run_d   = RW'(1);
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (in_seq) begin
            prev_d = idx;
            run_d  = run_q + 1'b1;
            if (run_d >= RW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            prev_d = idx;
            run_d  = RW'(1);
          end
        end
        LOCKED: begin
          if (in_seq) begin
            prev_d = idx;
            miss_d = '0;
          end else begin
            if (legal) begin
              seq_err_d = 1'b1;
              prev_d    = idx;
            end else begin
              prev_d = exp_up;
            end
            miss_d = miss_q + 1'b1;
            if (miss_d >= MW'(UNLOCK_ERRS)) begin
              state_d = HUNT;
              run_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM and tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      prev_q  <= '0;
      run_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
    end
  end

  assign take_err = (bus.jc_valid && !legal) || seq_err_d;

  // Registered decode result, pulses and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cnt_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      cnt_valid_q <= bus.jc_valid && legal;
      code_err_q  <= bus.jc_valid && !legal;
      seq_err_q   <= seq_err_d;
      if (bus.jc_valid && legal) cnt_q <= idx;
      if (take_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.code_err  = code_err_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jc_decoder.sv
// Self-checking bench for jc_decoder: directed scenarios plus random stream vs a table-driven model.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
// Outputs are sampled 1 time unit after each rising edge.
module tb_jc_decoder;

  localparam int W   = 4;
  localparam int N   = 2 * W;
  localparam int LC  = 4;
  localparam int UE  = 2;
`ifdef JC_DEC_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  jc_decoder_if #(.WIDTH(W), .ERR_CNT_W(8)) bus ();
  jc_decoder_if #(.WIDTH(W), .ERR_CNT_W(2)) bus2 ();

  jc_decoder #(.WIDTH(W), .LOCK_CNT(LC), .UNLOCK_ERRS(UE), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  jc_decoder #(.WIDTH(W), .LOCK_CNT(LC), .UNLOCK_ERRS(UE), .ERR_CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] jc_tab [N];
  int m_mode;           // 0 = hunting, 1 = checking, 2 = locked
  int m_prev, m_run, m_miss, m_cnt, m_err, m_err2, m_dir;
  bit m_cv, m_ce, m_se;

  function automatic void build_table();
    logic [W-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      jc_tab[k] = c;
      c = {~c[0], c[W-1:1]};
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_miss = 0;
    m_cnt = 0; m_err = 0; m_err2 = 0; m_dir = 0;
    m_cv = 0; m_ce = 0; m_se = 0;
  endfunction

  function automatic void model_step(input logic [W-1:0] code, input bit vld);
    int  idx, up, dn;
    bit  legal, instep;
    m_cv = 0; m_ce = 0; m_se = 0;
    if (!vld) return;
    idx = -1;
    for (int k = 0; k < N; k++) if (jc_tab[k] == code) idx = k;
    legal  = (idx >= 0);
    up     = (m_prev + 1) % N;
    dn     = (m_prev + N - 1) % N;
    instep = legal && (idx == up || (BIDIR && idx == dn));
    if (legal) begin m_cnt = idx; m_cv = 1; end
    else m_ce = 1;
    if (BIDIR && legal && m_mode != 0) begin
      if (idx == dn) m_dir = 1;
      else if (idx == up) m_dir = 0;
    end
    case (m_mode)
      0: if (legal) begin m_prev = idx; m_run = 1; m_mode = 1; end
      1: begin
        if (!legal) m_mode = 0;
        else if (instep) begin
          m_run++; m_prev = idx;
          if (m_run >= LC) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_prev = idx; m_run = 1;
        end
      end
      default: begin
        if (instep) begin
          m_miss = 0; m_prev = idx;
        end else begin
          if (legal) begin m_se = 1; m_prev = idx; end
          else m_prev = up;
          m_miss++;
          if (m_miss >= UE) begin m_mode = 0; m_run = 0; end
        end
      end
    endcase
    if (m_ce || m_se) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
    end
  endfunction

  task automatic check_outputs();
    chk("cnt",       32'(bus.cnt),       m_cnt);
    chk("cnt_valid", 32'(bus.cnt_valid), 32'(m_cv));
    chk("code_err",  32'(bus.code_err),  32'(m_ce));
    chk("seq_err",   32'(bus.seq_err),   32'(m_se));
    chk("locked",    32'(bus.locked),    32'(m_mode == 2));
    chk("err_cnt",   32'(bus.err_cnt),   m_err);
    chk("err_cnt_sat", 32'(bus2.err_cnt), m_err2);
`ifdef JC_DEC_BIDIR_EN
    chk("dir",       32'(bus.dir),       m_dir);
`endif
  endtask

  task automatic send(input logic [W-1:0] code, input bit vld);
    @(negedge clk);
    bus.jc_in  = code; bus.jc_valid  = vld;
    bus2.jc_in = code; bus2.jc_valid = vld;
    @(posedge clk);
    #1;
    model_step(code, vld);
    check_outputs();
  endtask

  task automatic send_idx(input int i);
    send(jc_tab[i], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rc;
    int r;
    build_table();
    model_reset();
    bus.jc_in = '0;  bus.jc_valid = 1'b0;
    bus2.jc_in = '0; bus2.jc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on the first four codes.
    for (int i = 0; i < 4; i++) send_idx(i);
    // Illegal code flywheels, next code still in sequence.
    send(4'b0101, 1'b1);
    send_idx(5);
    send_idx(6);
    // Single seq error recovers; two in a row drop lock.
    send_idx(1); send_idx(2);
    send_idx(1); send_idx(0);
    // Relock at 3..6, then wrap through 7 -> 0 with idle gaps.
    for (int i = 3; i <= 6; i++) send_idx(i);
    idle(3); send_idx(7); idle(3); send_idx(0); idle(3); send_idx(1);

    // Asynchronous reset between edges clears outputs before the next edge.
    send_idx(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    bus.jc_valid = 1'b0; bus2.jc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i <= 6; i++) send_idx(i);

    // Five illegal codes saturate the narrow counter.
    send(4'b0101, 1'b1); send(4'b1001, 1'b1); send(4'b0100, 1'b1);
    send(4'b1011, 1'b1); send(4'b0010, 1'b1);
    // Relock, then step downward 2,1,0,7.
    for (int i = 0; i < 4; i++) send_idx(i);
    send_idx(2); send_idx(1); send_idx(0); send_idx(7);

    // Random stream biased toward in-sequence steps.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      send('0, 1'b0);
      else if (r < 70) send_idx((m_prev + 1) % N);
      else if (r < 78) send_idx((m_prev + N - 1) % N);
      else if (r < 88) send_idx($urandom_range(0, N - 1));
      else begin
        rc = W'($urandom);
        send(rc, 1'b1);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jc_decoder.md
Name: jc_decoder

Overview:
Receive-side checker and decoder for the Johnson-counter code stream produced by our JC counter generators.
- Samples a WIDTH-bit Johnson code under a valid strobe and decodes it to a binary index 0..2*WIDTH-1.
- Flags illegal codes and out-of-sequence steps.
- Runs a hunt/lock state machine so downstream logic knows when the stream is trustworthy.
- Sits directly after the counter (or a link carrying its output) as the consumer end.

Parameters:
WIDTH, 4, Johnson code width; 2*WIDTH states; must be >= 2
LOCK_CNT, 4, consecutive in-sequence samples (including the seed) required to lock
UNLOCK_ERRS, 2, consecutive bad samples in LOCKED that force HUNT
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  reset; asynchronous, active-low
jc_in  in  WIDTH  Johnson code sample
jc_valid  in  1  jc_in is sampled this cycle
cnt  out  IW=$clog2(2*WIDTH)  decoded index of the last legal code
cnt_valid  out  1  one-cycle pulse: cnt updated
code_err  out  1  one-cycle pulse: illegal code sampled
seq_err  out  1  one-cycle pulse: legal code but not the expected step (LOCKED only)
locked  out  1  level: state == LOCKED
err_cnt  out  ERR_CNT_W  saturating count of code_err plus seq_err pulses

Behaviour:
- Reset values:
  - all outputs 0
  - state HUNT; prev index 0; run 0; miss 0
  - reset asserted mid-operation clears everything immediately; a full relock is required.
- Latency: every output is registered and reflects the jc_valid sample one cycle later.
- When jc_valid = 0: no state change; all pulses 0.
- Legal code: adjacent-bit transitions across jc_in[WIDTH-1:0] <= 1.
- Decode rule, p = popcount(jc_in):
  - MSB = 1: idx = p.
  - MSB = 0: idx = (2*WIDTH - p) mod 2*WIDTH.
  - WIDTH = 4 gives 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Expected next index: exp = (prev + 1) mod 2*WIDTH. Wrap from 2*WIDTH-1 to 0 is in-sequence.
- Every legal sample: cnt <= idx; cnt_valid pulses (any state).
- Every illegal sample: code_err pulses (any state); cnt holds.
- State machine (one-hot encoding):
  - HUNT:
    - Legal sample: prev <= idx, run <= 1, go CHECK.
    - Illegal sample: stay.
  - CHECK:
    - Legal sample with idx == exp: run++, prev <= idx; when run reaches LOCK_CNT, go LOCKED with miss <= 0.
    - Legal sample with idx != exp: re-seed (prev <= idx, run <= 1).
    - Illegal sample: go HUNT.
  - LOCKED:
    - In-sequence sample: miss <= 0, prev <= idx.
    - Legal out-of-sequence sample: seq_err pulses; prev <= idx (resync); miss++.
    - Illegal sample: prev <= exp (flywheel); miss++.
    - When miss reaches UNLOCK_ERRS: go HUNT, run <= 0.
- err_cnt: +1 per cycle in which code_err or seq_err pulses; saturates at all-ones.

Optional Feature:
Macro: JC_DEC_BIDIR_EN
- Defined:
  - Adds output port dir (1 bit, reset 0).
  - In CHECK and LOCKED, idx == (prev - 1) mod 2*WIDTH is also treated as in-sequence.
  - dir <= 1 on a down step and 0 on an up step, updated with cnt_valid.
  - A direction reversal is legal and does not reset run.
- Undefined: no dir port; a down step is out-of-sequence (seq_err in LOCKED).

Decomposition:
- Package jc_pkg holds:
  - state one-hot constants (HUNT, CHECK, LOCKED)
  - the index-width function clog2(2*WIDTH)
  - the shared code-legality and decode functions, so generator-side assertions reuse them
- Sub-module jc_code_classify: combinational; jc_in to {legal, idx}; instantiated once.
- FSM, counters and output registers stay in jc_decoder.

Test Plan:
1. Reset release, then jc_valid=1 on four consecutive cycles with 0000, 1000, 1100, 1110 -> cnt 0,1,2,3 each one cycle later; cnt_valid high for four cycles; locked rises with cnt=3; err_cnt 0.
2. Locked after 1110; send 0101, then 0111 -> code_err pulses once, cnt stays 3, err_cnt=1; the 0111 sample is in-sequence (flywheel expected 4, next 5), so locked stays 1.
3. Locked at 0011 (6); send 1000 (1), then 1100 (2) -> seq_err pulse, then no error, locked holds. Repeat with 1000 then 0000 -> two consecutive seq_err; locked falls one cycle after the second.
4. Locked; run 0011, 0001, 0000, 1000 with jc_valid low for 3 cycles between samples -> wrap 7 to 0 gives no seq_err; no pulses during gaps; cnt 6,7,0,1.
5. Locked; assert rst_n=0 mid-stream between clock edges -> locked, cnt, err_cnt read 0 before the next edge; after release, locked returns only after 4 in-sequence samples.
6. ERR_CNT_W=2; inject 5 illegal codes -> err_cnt 1,2,3,3,3 (saturates); with JC_DEC_BIDIR_EN, stream 2,1,0,7 -> dir=1, no seq_err.
